// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the priority encoder / arbiter.
// Imported by prio_find and prio_enc_arb.
package prio_enc_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   localparam int MAX_N = 256;

   // True when more than one bit of v is set; narrower vectors are zero-extended.
   function automatic logic multi_hot(input logic [MAX_N-1:0] v);
      logic [MAX_N-1:0] low_clr;
      low_clr = v & (v - MAX_N'(1));
      return |low_clr;
   endfunction

endpackage

// File: rtl/prio_enc_arb_find.sv
// Combinational first-set-bit search starting at a rotating base index.
// Doubling the vector turns the wrap-around scan into a plain slice.
module prio_find
   import prio_enc_pkg::*;
#(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec_i,
   input  logic [W-1:0] start_i,
   output logic [W-1:0] idx_o,
   output logic         found_o
);

   localparam logic [W:0] NW = N[W:0];

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   off;
   logic [W:0]     sum;

   assign dbl = {vec_i, vec_i};
   assign rot = dbl[start_i +: N];

   // Lowest set bit of the rotated vector, mapped back to an absolute index.
   always_comb begin
      off     = '0;
      found_o = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off     = i[W-1:0];
            found_o = 1'b1;
         end
      end
      sum = {1'b0, start_i} + {1'b0, off};
      if (sum >= NW) sum = sum - NW;
      idx_o = sum[W-1:0];
   end

endmodule

// File: rtl/prio_enc_arb.sv
// Registered priority encoder with fixed or round-robin selection.
// Result sits in a valid/ready output register; stalls hold it stable.
module prio_enc_arb
   import prio_enc_pkg::*;
#(
   parameter int N    = 8,
   parameter int W    = $clog2(N),
   parameter int MODE = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req_i,
   input  logic         en_i,
   output logic [W-1:0] idx_o,
   output logic [N-1:0] gnt_o,
   output logic         valid_o,
   input  logic         ready_i,
   output logic         multi_o,
   output logic [W-1:0] ptr_o
);

   localparam logic [W:0] NW = N[W:0];

   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] gnt_q, gnt_d;
   logic         valid_q, valid_d;
   logic         multi_q, multi_d;
   logic [W-1:0] ptr_q, ptr_d;

   logic [W-1:0] start;
   logic [W-1:0] sel;
   logic         found;
   logic         cap;
   logic [W:0]   nxt;

   assign start = (MODE == MODE_RR) ? ptr_q : '0;

   prio_find #(.N(N), .W(W)) u_find (
      .vec_i   (req_i),
      .start_i (start),
      .idx_o   (sel),
      .found_o (found)
   );

   assign cap = en_i && found && (!valid_q || ready_i);
   assign nxt = {1'b0, sel} + {{W{1'b0}}, 1'b1};

   // Next-state: capture, drain on handshake, otherwise hold.
   always_comb begin
      idx_d   = idx_q;
      gnt_d   = gnt_q;
      valid_d = valid_q;
      multi_d = multi_q;
      ptr_d   = ptr_q;
      if (cap) begin
         idx_d        = sel;
         gnt_d        = '0;
         gnt_d[sel]   = 1'b1;
         valid_d      = 1'b1;
         multi_d      = multi_hot(MAX_N'(req_i));
         if (MODE == MODE_RR)
            ptr_d = (nxt == NW) ? '0 : nxt[W-1:0];
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
         gnt_d   = '0;
      end
   end

   // Result and pointer registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         gnt_q   <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         ptr_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         ptr_q   <= ptr_d;
      end
   end

   assign idx_o   = idx_q;
   assign gnt_o   = gnt_q;
   assign valid_o = valid_q;
   assign multi_o = multi_q;
   assign ptr_o   = ptr_q;

endmodule

// File: tb/tb_prio_enc_arb.sv
// Directed bench for prio_enc_arb: fixed N=8, round-robin N=8 and N=5.
// Inputs change after the edge; outputs are sampled 1 time unit after it.
module tb_prio_enc_arb;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req8;
   logic [4:0] req5;
   logic       en;
   logic       ready;

   logic [2:0] idx0, ptr0, idx1, ptr1, idx5, ptr5;
   logic [7:0] gnt0, gnt1;
   logic [4:0] gnt5;
   logic       val0, val1, val5, mul0, mul1, mul5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prio_enc_arb #(.N(8), .MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req_i(req8), .en_i(en),
      .idx_o(idx0), .gnt_o(gnt0), .valid_o(val0), .ready_i(ready),
      .multi_o(mul0), .ptr_o(ptr0)
   );

   prio_enc_arb #(.N(8), .MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_i(req8), .en_i(en),
      .idx_o(idx1), .gnt_o(gnt1), .valid_o(val1), .ready_i(ready),
      .multi_o(mul1), .ptr_o(ptr1)
   );

   prio_enc_arb #(.N(5), .MODE(1)) u5 (
      .clk(clk), .rst_n(rst_n), .req_i(req5), .en_i(en),
      .idx_o(idx5), .gnt_o(gnt5), .valid_o(val5), .ready_i(ready),
      .multi_o(mul5), .ptr_o(ptr5)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   int exp_idx[5] = '{1, 4, 7, 1, 4};
   int exp_ptr[5] = '{2, 5, 0, 2, 5};
   int e5_idx[3]  = '{0, 4, 0};
   int e5_ptr[3]  = '{1, 0, 1};

   initial begin
      rst_n = 1'b0;
      req8  = 8'hFF;
      req5  = '0;
      en    = 1'b1;
      ready = 1'b1;

      // 1: reset overrides an active capture for two edges
      step();
      step();
      chk("rst_idx",   32'(idx0), 0);
      chk("rst_gnt",   32'(gnt0), 0);
      chk("rst_valid", 32'(val0), 0);
      chk("rst_multi", 32'(mul0), 0);
      chk("rst_ptr1",  32'(ptr1), 0);
      rst_n = 1'b1;
      step();
      chk("first_idx",   32'(idx0), 0);
      chk("first_gnt",   32'(gnt0), 32'h01);
      chk("first_valid", 32'(val0), 1);
      chk("first_multi", 32'(mul0), 1);

      // 2: fixed priority, walking one-hot at full throughput
      do_reset();
      for (int i = 0; i < 8; i++) begin
         req8 = 8'(1 << i);
         step();
         chk("walk_idx",   32'(idx0), 32'(i));
         chk("walk_gnt",   32'(gnt0), 32'(1 << i));
         chk("walk_valid", 32'(val0), 1);
         chk("walk_multi", 32'(mul0), 0);
      end

      // 3: round-robin over 8'b1001_0010
      do_reset();
      req8 = 8'b1001_0010;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_idx",   32'(idx1), 32'(exp_idx[i]));
         chk("rr_ptr",   32'(ptr1), 32'(exp_ptr[i]));
         chk("rr_gnt",   32'(gnt1), 32'(1 << exp_idx[i]));
         chk("rr_multi", 32'(mul1), 1);
         chk("fix_idx",  32'(idx0), 1);
         chk("fix_ptr",  32'(ptr0), 0);
      end

      // 4: stall holds the result, new request ignored until ready
      do_reset();
      req8 = 8'h04;
      step();
      chk("stall_cap", 32'(idx0), 2);
      ready = 1'b0;
      req8  = 8'h20;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_idx",   32'(idx0), 2);
         chk("stall_gnt",   32'(gnt0), 32'h04);
         chk("stall_valid", 32'(val0), 1);
      end
      ready = 1'b1;
      step();
      chk("unstall_idx", 32'(idx0), 5);
      chk("unstall_gnt", 32'(gnt0), 32'h20);

      // 5: N=5 round-robin wrap from index 4 back to 0
      req8 = '0;
      do_reset();
      req5 = 5'b10001;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("n5_idx",   32'(idx5), 32'(e5_idx[i]));
         chk("n5_ptr",   32'(ptr5), 32'(e5_ptr[i]));
         chk("n5_gnt",   32'(gnt5), 32'(1 << e5_idx[i]));
         chk("n5_valid", 32'(val5), 1);
      end
      req5 = '0;

      // 6: drain on empty request, then disabled capture
      do_reset();
      req8 = 8'h08;
      step();
      chk("drain_cap", 32'(val0), 1);
      req8 = 8'h00;
      step();
      chk("drain_valid", 32'(val0), 0);
      chk("drain_gnt",   32'(gnt0), 0);
      chk("drain_idx",   32'(idx0), 3);
      en   = 1'b0;
      req8 = 8'hFF;
      step();
      chk("dis_valid", 32'(val0), 0);
      step();
      chk("dis_valid2", 32'(val0), 0);
      chk("dis_idx",    32'(idx0), 3);
      chk("dis_gnt",    32'(gnt0), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
